// File: rtl/starship_pkg.sv
// -----------------------------------------------------------------------------
// starship_pkg
// Shared constants for the Starship console blocks:
//   - PS/2 set-2 scan codes (break/extended prefixes, Enter, hex keys 0-9/A-F)
//   - PS/2 receiver FSM state encoding
//   - hex_lookup(): maps a set-2 make code to {hit, digit}
// The SSD hex table and the repair modules import this package as well.
// -----------------------------------------------------------------------------
package starship_pkg;

  // Prefix and control codes
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_ENTER = 8'h5A;

  // Hex key make codes
  localparam logic [7:0] SC_KEY_0 = 8'h45;
  localparam logic [7:0] SC_KEY_1 = 8'h16;
  localparam logic [7:0] SC_KEY_2 = 8'h1E;
  localparam logic [7:0] SC_KEY_3 = 8'h26;
  localparam logic [7:0] SC_KEY_4 = 8'h25;
  localparam logic [7:0] SC_KEY_5 = 8'h2E;
  localparam logic [7:0] SC_KEY_6 = 8'h36;
  localparam logic [7:0] SC_KEY_7 = 8'h3D;
  localparam logic [7:0] SC_KEY_8 = 8'h3E;
  localparam logic [7:0] SC_KEY_9 = 8'h46;
  localparam logic [7:0] SC_KEY_A = 8'h1C;
  localparam logic [7:0] SC_KEY_B = 8'h32;
  localparam logic [7:0] SC_KEY_C = 8'h21;
  localparam logic [7:0] SC_KEY_D = 8'h23;
  localparam logic [7:0] SC_KEY_E = 8'h24;
  localparam logic [7:0] SC_KEY_F = 8'h2B;

  // PS/2 receiver frame states
  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } ps2_state_t;

  // Returns {hit, digit}; hit=0 when the byte is not a hex key.
  function automatic logic [4:0] hex_lookup(input logic [7:0] sc);
    logic [4:0] r;
    r = 5'h00;
    case (sc)
      SC_KEY_0: r = {1'b1, 4'h0};
      SC_KEY_1: r = {1'b1, 4'h1};
      SC_KEY_2: r = {1'b1, 4'h2};
      SC_KEY_3: r = {1'b1, 4'h3};
      SC_KEY_4: r = {1'b1, 4'h4};
      SC_KEY_5: r = {1'b1, 4'h5};
      SC_KEY_6: r = {1'b1, 4'h6};
      SC_KEY_7: r = {1'b1, 4'h7};
      SC_KEY_8: r = {1'b1, 4'h8};
      SC_KEY_9: r = {1'b1, 4'h9};
      SC_KEY_A: r = {1'b1, 4'hA};
      SC_KEY_B: r = {1'b1, 4'hB};
      SC_KEY_C: r = {1'b1, 4'hC};
      SC_KEY_D: r = {1'b1, 4'hD};
      SC_KEY_E: r = {1'b1, 4'hE};
      SC_KEY_F: r = {1'b1, 4'hF};
      default:  r = 5'h00;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/starship_ps2_filter.sv
// -----------------------------------------------------------------------------
// starship_ps2_filter
// Conditions the raw PS/2 clock: 2-FF synchroniser, FILTER_LEN stability
// filter, and a 1-cycle strobe on each accepted 1->0 transition.
// Ports:
//   board_clk  in  system clock
//   Reset      in  asynchronous, active-high reset
//   i_raw      in  raw asynchronous line (idle high)
//   o_fall     out 1-cycle strobe on a filtered falling edge
// -----------------------------------------------------------------------------
module starship_ps2_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic board_clk,
  input  logic Reset,
  input  logic i_raw,
  output logic o_fall
);

  localparam int CW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(FILTER_LEN - 1);

  logic          r_meta;
  logic          r_sync;
  logic          r_level;
  logic [CW-1:0] r_cnt;
  logic          r_fall;

  // Sync and filtered level reset to the idle-high line level so that
  // leaving reset never produces a spurious falling edge.
  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      r_meta  <= 1'b1;
      r_sync  <= 1'b1;
      r_level <= 1'b1;
      r_cnt   <= '0;
      r_fall  <= 1'b0;
    end else begin
      r_meta <= i_raw;
      r_sync <= r_meta;
      r_fall <= 1'b0;
      if (r_sync == r_level) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_LAST) begin
        // FILTER_LEN consecutive samples disagree with the held level
        r_level <= r_sync;
        r_cnt   <= '0;
        r_fall  <= r_level;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_fall = r_fall;

endmodule

// File: rtl/starship_ps2_hex_rx.sv
// -----------------------------------------------------------------------------
// starship_ps2_hex_rx
// PS/2 keyboard receiver replacing the Sw3..Sw0 switch entry. Deserialises
// device-to-host frames, decodes set-2 make codes for keys 0-9/A-F into a held
// hex digit, and turns a bare Enter make code into a submit pulse.
// Ports:
//   board_clk   in   1  system clock (100 MHz)
//   Reset       in   1  asynchronous, active-high reset
//   PS2Clk      in   1  raw keyboard clock
//   PS2Data     in   1  raw keyboard data
//   scan_code   out  8  last good frame byte
//   code_valid  out  1  pulse per good frame
//   hex_combo   out  4  last hex digit pressed
//   hex_valid   out  1  pulse when hex_combo updates
//   enter_pulse out  1  pulse on non-extended Enter make
//   frame_err   out  1  pulse on parity/stop error or timeout
//   busy        out  1  frame in progress
//   dbg_state   out  2  receiver FSM state
// -----------------------------------------------------------------------------
module starship_ps2_hex_rx
  import starship_pkg::*;
#(
  parameter int FILTER_LEN  = 8,
  parameter int TIMEOUT_CYC = 200000
) (
  input  logic       board_clk,
  input  logic       Reset,
  input  logic       PS2Clk,
  input  logic       PS2Data,
  output logic [7:0] scan_code,
  output logic       code_valid,
  output logic [3:0] hex_combo,
  output logic       hex_valid,
  output logic       enter_pulse,
  output logic       frame_err,
  output logic       busy,
  output logic [1:0] dbg_state
);

  localparam int WD_W = $clog2(TIMEOUT_CYC + 1);
  localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT_CYC - 1);

  logic            w_fall;
  logic            r_data_meta;
  logic            r_data_sync;

  ps2_state_t      r_state;
  ps2_state_t      w_state_next;
  logic [2:0]      r_bit_cnt;
  logic [7:0]      r_shift;
  logic            r_par;
  logic [WD_W-1:0] r_wdog;
  logic            r_brk_f;
  logic            r_ext_f;

  logic            w_frame_ok;
  logic            w_frame_bad;
  logic            w_timeout;
  logic            w_parity_ok;
  logic [4:0]      w_hex;

  logic [7:0]      r_scan_code;
  logic            r_code_valid;
  logic [3:0]      r_hex_combo;
  logic            r_hex_valid;
  logic            r_enter_pulse;
  logic            r_frame_err;
  logic            r_busy;

  starship_ps2_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filter (
    .board_clk (board_clk),
    .Reset     (Reset),
    .i_raw     (PS2Clk),
    .o_fall    (w_fall)
  );

  // Data only needs synchronising: it is sampled on the filtered clock edge,
  // which lags the raw edge by the filter delay, so data is long settled.
  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      r_data_meta <= 1'b1;
      r_data_sync <= 1'b1;
    end else begin
      r_data_meta <= PS2Data;
      r_data_sync <= r_data_meta;
    end
  end

  // Odd parity: data bits plus parity bit must XOR to 1
  assign w_parity_ok = ^{r_shift, r_par};
  assign w_hex       = hex_lookup(r_shift);
  assign w_timeout   = (r_state != ST_IDLE) && !w_fall && (r_wdog == WD_LAST);

  always_comb begin
    w_state_next = r_state;
    w_frame_ok   = 1'b0;
    w_frame_bad  = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (w_fall && !r_data_sync) w_state_next = ST_DATA;
      end
      ST_DATA: begin
        if (w_fall && (r_bit_cnt == 3'd7)) w_state_next = ST_PARITY;
      end
      ST_PARITY: begin
        if (w_fall) w_state_next = ST_STOP;
      end
      ST_STOP: begin
        if (w_fall) begin
          w_state_next = ST_IDLE;
          if (r_data_sync && w_parity_ok) w_frame_ok  = 1'b1;
          else                            w_frame_bad = 1'b1;
        end
      end
      default: w_state_next = ST_IDLE;
    endcase
    if (w_timeout) begin
      w_state_next = ST_IDLE;
      w_frame_bad  = 1'b1;
    end
  end

  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      r_state       <= ST_IDLE;
      r_bit_cnt     <= 3'd0;
      r_shift       <= 8'h00;
      r_par         <= 1'b0;
      r_wdog        <= '0;
      r_brk_f       <= 1'b0;
      r_ext_f       <= 1'b0;
      r_scan_code   <= 8'h00;
      r_code_valid  <= 1'b0;
      r_hex_combo   <= 4'h0;
      r_hex_valid   <= 1'b0;
      r_enter_pulse <= 1'b0;
      r_frame_err   <= 1'b0;
      r_busy        <= 1'b0;
    end else begin
      r_state       <= w_state_next;
      r_busy        <= (w_state_next != ST_IDLE);
      r_code_valid  <= 1'b0;
      r_hex_valid   <= 1'b0;
      r_enter_pulse <= 1'b0;
      r_frame_err   <= 1'b0;

      // Watchdog measures the gap since the last falling edge of this frame
      if ((r_state == ST_IDLE) || w_fall) r_wdog <= '0;
      else                                r_wdog <= r_wdog + WD_W'(1);

      if (w_fall) begin
        if (r_state == ST_IDLE)   r_bit_cnt <= 3'd0;
        if (r_state == ST_DATA) begin
          r_shift   <= {r_data_sync, r_shift[7:1]};
          r_bit_cnt <= r_bit_cnt + 3'd1;
        end
        if (r_state == ST_PARITY) r_par <= r_data_sync;
      end

      if (w_frame_bad) begin
        r_frame_err <= 1'b1;
        r_brk_f     <= 1'b0;
        r_ext_f     <= 1'b0;
      end

      if (w_frame_ok) begin
        r_scan_code  <= r_shift;
        r_code_valid <= 1'b1;
        if (r_shift == SC_BRK) begin
          r_brk_f <= 1'b1;
        end else if (r_shift == SC_EXT) begin
          r_ext_f <= 1'b1;
        end else if (r_brk_f) begin
          // Release of any key (extended or not): no decode
          r_brk_f <= 1'b0;
          r_ext_f <= 1'b0;
        end else if (r_ext_f) begin
          // Extended make (e.g. keypad Enter): not a console key
          r_ext_f <= 1'b0;
        end else if (w_hex[4]) begin
          r_hex_combo <= w_hex[3:0];
          r_hex_valid <= 1'b1;
        end else if (r_shift == SC_ENTER) begin
          r_enter_pulse <= 1'b1;
        end
      end
    end
  end

  assign scan_code   = r_scan_code;
  assign code_valid  = r_code_valid;
  assign hex_combo   = r_hex_combo;
  assign hex_valid   = r_hex_valid;
  assign enter_pulse = r_enter_pulse;
  assign frame_err   = r_frame_err;
  assign busy        = r_busy;
  assign dbg_state   = r_state;

endmodule

// File: tb/tb_starship_ps2_hex_rx.sv
// -----------------------------------------------------------------------------
// tb_starship_ps2_hex_rx
// Directed frames into starship_ps2_hex_rx. The PS/2 clock is scaled down
// (20 board_clk half period) and the timeout shortened so the run stays short.
// -----------------------------------------------------------------------------
module tb_starship_ps2_hex_rx;

  localparam int FL = 8;
  localparam int TO = 400;
  localparam int HP = 20;

  logic       board_clk;
  logic       Reset;
  logic       PS2Clk;
  logic       PS2Data;
  logic [7:0] scan_code;
  logic       code_valid;
  logic [3:0] hex_combo;
  logic       hex_valid;
  logic       enter_pulse;
  logic       frame_err;
  logic       busy;
  logic [1:0] dbg_state;

  starship_ps2_hex_rx #(.FILTER_LEN(FL), .TIMEOUT_CYC(TO)) dut (
    .board_clk   (board_clk),
    .Reset       (Reset),
    .PS2Clk      (PS2Clk),
    .PS2Data     (PS2Data),
    .scan_code   (scan_code),
    .code_valid  (code_valid),
    .hex_combo   (hex_combo),
    .hex_valid   (hex_valid),
    .enter_pulse (enter_pulse),
    .frame_err   (frame_err),
    .busy        (busy),
    .dbg_state   (dbg_state)
  );

  // ---------------- clock / reset ----------------
  initial board_clk = 1'b0;
  always #5 board_clk = ~board_clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: sim time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q[$];
  int n_code, n_hex, n_enter, n_err;
  logic prev_cv, prev_hv, prev_ep, prev_fe;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, act, exp);
    end
  endtask

  always @(negedge board_clk) begin
    if (Reset) begin
      prev_cv = 1'b0; prev_hv = 1'b0; prev_ep = 1'b0; prev_fe = 1'b0;
    end else begin
      if (code_valid) begin
        n_code++;
        if (exp_q.size() == 0) chk("scan_unexpected", {24'h0, scan_code}, 32'hFFFF);
        else                   chk("scan_code", {24'h0, scan_code}, {24'h0, exp_q.pop_front()});
        chk("cv_width", {31'h0, prev_cv}, 0);
      end
      if (hex_valid)   begin n_hex++;   chk("hv_width", {31'h0, prev_hv}, 0); end
      if (enter_pulse) begin n_enter++; chk("ep_width", {31'h0, prev_ep}, 0); end
      if (frame_err)   begin n_err++;   chk("fe_width", {31'h0, prev_fe}, 0); end
      prev_cv = code_valid; prev_hv = hex_valid; prev_ep = enter_pulse; prev_fe = frame_err;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge board_clk);
  endtask

  task automatic clear_counts();
    n_code = 0; n_hex = 0; n_enter = 0; n_err = 0;
  endtask

  function automatic logic [10:0] mk_frame(input logic [7:0] b, input bit bad_par, input bit bad_stop);
    logic p;
    p = (~^b) ^ bad_par;
    return {~bad_stop, p, b, 1'b0};
  endfunction

  // Sends the first nbits of a frame; data changes while the clock is high.
  task automatic send_bits(input logic [10:0] f, input int nbits, input bit glitch);
    for (int i = 0; i < nbits; i++) begin
      PS2Data = f[i];
      if (glitch) begin
        cyc(4);
        PS2Clk = 1'b0;
        cyc(3);
        PS2Clk = 1'b1;
        cyc(HP / 2);
      end else begin
        cyc(HP / 2);
      end
      PS2Clk = 1'b0;
      cyc(HP);
      PS2Clk = 1'b1;
      cyc(HP / 2);
    end
    PS2Data = 1'b1;
  endtask

  task automatic send_good(input logic [7:0] b);
    exp_q.push_back(b);
    send_bits(mk_frame(b, 1'b0, 1'b0), 11, 1'b0);
    cyc(10);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    clear_counts();
    Reset   = 1'b1;
    PS2Clk  = 1'b1;
    PS2Data = 1'b1;
    cyc(3);
    chk("rst_scan",  {24'h0, scan_code}, 0);
    chk("rst_cv",    {31'h0, code_valid}, 0);
    chk("rst_hex",   {28'h0, hex_combo}, 0);
    chk("rst_hv",    {31'h0, hex_valid}, 0);
    chk("rst_enter", {31'h0, enter_pulse}, 0);
    chk("rst_err",   {31'h0, frame_err}, 0);
    chk("rst_busy",  {31'h0, busy}, 0);
    chk("rst_state", {30'h0, dbg_state}, 0);
    Reset = 1'b0;
    cyc(20);

    // 1: single hex key
    clear_counts();
    send_good(8'h1C);
    chk("t1_ncode", n_code, 1);
    chk("t1_nhex",  n_hex, 1);
    chk("t1_hex",   {28'h0, hex_combo}, 32'hA);
    chk("t1_scan",  {24'h0, scan_code}, 32'h1C);
    chk("t1_busy",  {31'h0, busy}, 0);

    // 2: make, break, release
    clear_counts();
    send_good(8'h16);
    send_good(8'hF0);
    send_good(8'h16);
    chk("t2_ncode", n_code, 3);
    chk("t2_nhex",  n_hex, 1);
    chk("t2_hex",   {28'h0, hex_combo}, 1);

    // 3: extended Enter ignored, bare Enter submits
    clear_counts();
    send_good(8'hE0);
    send_good(8'h5A);
    chk("t3_enter_ext", n_enter, 0);
    send_good(8'h5A);
    chk("t3_enter", n_enter, 1);
    chk("t3_ncode", n_code, 3);
    chk("t3_nhex",  n_hex, 0);

    // 4: parity error
    clear_counts();
    send_bits(mk_frame(8'h45, 1'b1, 1'b0), 11, 1'b0);
    cyc(10);
    chk("t4_nerr",  n_err, 1);
    chk("t4_ncode", n_code, 0);
    chk("t4_hex",   {28'h0, hex_combo}, 1);

    // 5: stop-bit error then recovery
    clear_counts();
    send_bits(mk_frame(8'h1E, 1'b0, 1'b1), 11, 1'b0);
    cyc(10);
    chk("t5_nerr",  n_err, 1);
    chk("t5_ncode", n_code, 0);
    chk("t5_hex_hold", {28'h0, hex_combo}, 1);
    send_good(8'h26);
    chk("t5_hex",   {28'h0, hex_combo}, 3);
    chk("t5_nhex",  n_hex, 1);

    // 6: timeout mid-frame then recovery
    clear_counts();
    send_bits(mk_frame(8'h55, 1'b0, 1'b0), 5, 1'b0);
    cyc(2);
    chk("t6_busy_mid", {31'h0, busy}, 1);
    cyc(TO + 50);
    chk("t6_nerr",  n_err, 1);
    chk("t6_busy",  {31'h0, busy}, 0);
    chk("t6_ncode", n_code, 0);
    send_good(8'h2B);
    chk("t6_hex",   {28'h0, hex_combo}, 32'hF);
    chk("t6_nerr2", n_err, 1);

    // 7: short clock glitches ahead of every bit
    clear_counts();
    exp_q.push_back(8'h3D);
    send_bits(mk_frame(8'h3D, 1'b0, 1'b0), 11, 1'b1);
    cyc(10);
    chk("t7_ncode", n_code, 1);
    chk("t7_nerr",  n_err, 0);
    chk("t7_hex",   {28'h0, hex_combo}, 7);

    // 8: reset mid-frame
    clear_counts();
    send_bits(mk_frame(8'h24, 1'b0, 1'b0), 5, 1'b0);
    Reset = 1'b1;
    #1;
    chk("t8_busy",  {31'h0, busy}, 0);
    chk("t8_hex",   {28'h0, hex_combo}, 0);
    chk("t8_scan",  {24'h0, scan_code}, 0);
    chk("t8_state", {30'h0, dbg_state}, 0);
    cyc(3);
    Reset = 1'b0;
    cyc(20);
    clear_counts();
    send_good(8'h3E);
    chk("t8_hex_after", {28'h0, hex_combo}, 8);
    chk("t8_nhex",  n_hex, 1);
    chk("t8_nerr",  n_err, 0);

    chk("q_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
